// File: rtl/cheat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cheat_pkg
//  Description : Shared constants and FSM encoding for the cheat engine
//                programming sequencer and its shadow table.
//  Revision    : 1.0 - initial release
// ============================================================================
package cheat_pkg;

    // Programming-port index of the patch enable mask word
    localparam logic [2:0] PGM_IDX_MASK = 3'd6;
    // Programming-port index of the control flags word
    localparam logic [2:0] PGM_IDX_CTRL = 3'd7;
    // Number of patch entries held by the cheat engine
    localparam int         CHEAT_NUM    = 6;

    // Control word: low nibble sets flags, high nibble resets them
    localparam logic [3:0] CTRL_CHEAT_EN_SET = 4'h1;
    localparam logic [7:0] CTRL_CHEAT_EN_RST = 8'h01 << 4;

    // Shadow table geometry
    localparam int SHADOW_DEPTH = 8;
    localparam int PGM_W        = 32;

    // Sequencer states (3-bit encoding)
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_ENTRY   = 3'd2,
        ST_MASK    = 3'd3,
        ST_FLAGS   = 3'd4,
        ST_DONE    = 3'd5,
        ST_GAP     = 3'd6
    } seq_state_t;

    // True for the states that present a word on the programming port
    function automatic logic is_word_state(input seq_state_t s);
        return (s == ST_QUIESCE) || (s == ST_ENTRY) ||
               (s == ST_MASK)    || (s == ST_FLAGS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cheat_shadow_table.sv
`default_nettype none
// ============================================================================
//  Module      : cheat_shadow_table
//  Description : 8x32 shadow register file written by the MCU. One write
//                port, one asynchronous read port, synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module cheat_shadow_table
    import cheat_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [PGM_W-1:0]  wr_data,
    input  logic [2:0]        rd_addr,
    output logic [PGM_W-1:0]  rd_data
);

    logic [PGM_W-1:0] mem_q [SHADOW_DEPTH];
    logic [PGM_W-1:0] mem_d [SHADOW_DEPTH];

    // Next table contents: a single entry may be overwritten per cycle
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Table storage with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/cheat_pgm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cheat_pgm_sequencer
//  Description : Replays the MCU shadow table into the cheat engine's
//                programming port: quiesce, 6 patch entries, mask, flags.
//                Words rejected because of a concurrent SNES snescmd write
//                are reissued until accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module cheat_pgm_sequencer
    import cheat_pkg::*;
#(
    parameter int          WR_GAP       = 2,
    parameter logic [31:0] QUIESCE_WORD = 32'h0000_0010
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        mcu_wr_strobe,
    input  logic [2:0]  mcu_addr,
    input  logic [31:0] mcu_data,
    input  logic        mcu_commit,
    input  logic        snescmd_wr_busy,
    output logic [2:0]  pgm_idx,
    output logic        pgm_we,
    output logic [31:0] pgm_in,
    output logic        busy,
    output logic        done_strobe,
    output logic [7:0]  retry_cnt
);

    seq_state_t  state_q,  state_d;
    seq_state_t  resume_q, resume_d;
    logic [2:0]  ent_k_q,  ent_k_d;
    logic [3:0]  gap_q,    gap_d;
    logic        pending_q, pending_d;
    logic [7:0]  retry_q,  retry_d;
    logic        we_q,     we_d;
    logic [2:0]  idx_q,    idx_d;
    logic [31:0] in_q,     in_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;

    seq_state_t  fol_state;
    logic [2:0]  fol_k;
    logic        stall;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;

    cheat_shadow_table u_shadow (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mcu_wr_strobe),
        .wr_addr (mcu_addr),
        .wr_data (mcu_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Word that follows the one currently presented on the port
    always_comb begin
        fol_state = ST_DONE;
        fol_k     = ent_k_q;
        case (state_q)
            ST_QUIESCE: begin
                fol_state = ST_ENTRY;
                fol_k     = 3'd0;
            end
            ST_ENTRY: begin
                if (ent_k_q == 3'(CHEAT_NUM - 1)) begin
                    fol_state = ST_MASK;
                end else begin
                    fol_state = ST_ENTRY;
                    fol_k     = ent_k_q + 3'd1;
                end
            end
            ST_MASK:  fol_state = ST_FLAGS;
            default:  fol_state = ST_DONE;
        endcase
    end

    // Sequencing: issue / retry / gap / done, plus commit coalescing
    always_comb begin
        state_d   = state_q;
        resume_d  = resume_q;
        ent_k_d   = ent_k_q;
        gap_d     = gap_q;
        pending_d = pending_q;
        retry_d   = retry_q;
        case (state_q)
            ST_IDLE: begin
                if (mcu_commit || pending_q) begin
                    state_d   = ST_QUIESCE;
                    pending_d = 1'b0;
                end
            end
            ST_QUIESCE, ST_ENTRY, ST_MASK, ST_FLAGS: begin
                if (mcu_commit) begin
                    pending_d = 1'b1;
                end
                if (snescmd_wr_busy) begin
                    // Engine ignored this pulse; hold the word and count it
                    if (retry_q != 8'hff) begin
                        retry_d = retry_q + 8'd1;
                    end
                end else begin
                    ent_k_d = fol_k;
                    // No gap after the flags word: DONE follows directly
                    if ((fol_state == ST_DONE) || (WR_GAP == 0)) begin
                        state_d = fol_state;
                    end else begin
                        state_d  = ST_GAP;
                        resume_d = fol_state;
                        gap_d    = 4'(WR_GAP - 1);
                    end
                end
            end
            ST_GAP: begin
                if (mcu_commit) begin
                    pending_d = 1'b1;
                end
                if (gap_q == 4'd0) begin
                    state_d = resume_q;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            ST_DONE: begin
                // A commit seen during the replay (or right now) reruns it
                if (pending_q || mcu_commit) begin
                    state_d   = ST_QUIESCE;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the next cycle; idx/in load only when a new word starts
    always_comb begin
        stall = snescmd_wr_busy && is_word_state(state_q);
        case (state_d)
            ST_ENTRY: rd_addr = ent_k_d;
            ST_MASK:  rd_addr = PGM_IDX_MASK;
            default:  rd_addr = PGM_IDX_CTRL;
        endcase
        we_d   = is_word_state(state_d);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        idx_d  = idx_q;
        in_d   = in_q;
        if (we_d && !stall) begin
            idx_d = rd_addr;
            in_d  = (state_d == ST_QUIESCE) ? QUIESCE_WORD : rd_data;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            resume_q  <= ST_IDLE;
            ent_k_q   <= '0;
            gap_q     <= '0;
            pending_q <= 1'b0;
            retry_q   <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            in_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            resume_q  <= resume_d;
            ent_k_q   <= ent_k_d;
            gap_q     <= gap_d;
            pending_q <= pending_d;
            retry_q   <= retry_d;
            we_q      <= we_d;
            idx_q     <= idx_d;
            in_q      <= in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign pgm_we      = we_q;
    assign pgm_idx     = idx_q;
    assign pgm_in      = in_q;
    assign busy        = busy_q;
    assign done_strobe = done_q;
    assign retry_cnt   = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_cheat_pgm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cheat_pgm_sequencer
//  Description : Self-checking bench for cheat_pgm_sequencer. Two instances
//                (word gap 2 and word gap 0) share stimulus; a word-level
//                reference model predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cheat_pgm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mcu_wr_strobe;
    logic [2:0]  mcu_addr;
    logic [31:0] mcu_data;
    logic        mcu_commit;
    logic        snescmd_wr_busy;

    logic [2:0]  a_idx,  b_idx;
    logic        a_we,   b_we;
    logic [31:0] a_in,   b_in;
    logic        a_busy, b_busy;
    logic        a_done, b_done;
    logic [7:0]  a_retry, b_retry;

    always #5 clk = ~clk;

    cheat_pgm_sequencer #(.WR_GAP(2)) dut (
        .clk(clk), .reset(reset), .mcu_wr_strobe(mcu_wr_strobe), .mcu_addr(mcu_addr),
        .mcu_data(mcu_data), .mcu_commit(mcu_commit), .snescmd_wr_busy(snescmd_wr_busy),
        .pgm_idx(a_idx), .pgm_we(a_we), .pgm_in(a_in), .busy(a_busy),
        .done_strobe(a_done), .retry_cnt(a_retry)
    );

    cheat_pgm_sequencer #(.WR_GAP(0)) dut_nogap (
        .clk(clk), .reset(reset), .mcu_wr_strobe(mcu_wr_strobe), .mcu_addr(mcu_addr),
        .mcu_data(mcu_data), .mcu_commit(mcu_commit), .snescmd_wr_busy(snescmd_wr_busy),
        .pgm_idx(b_idx), .pgm_we(b_we), .pgm_in(b_in), .busy(b_busy),
        .done_strobe(b_done), .retry_cnt(b_retry)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: phase 0 idle, 1 replaying, 2 done cycle.
    // word 0..8 = quiesce, entries 0..5, mask, flags; cd = cycles until issue.
    int          m_phase [2];
    int          m_word  [2];
    int          m_cd    [2];
    bit          m_pend  [2];
    logic [7:0]  m_retry [2];
    logic [2:0]  m_idx   [2];
    logic [31:0] m_in    [2];
    logic [31:0] m_sh    [2][8];

    // Monitors
    int first_we_a, first_we_b, we_a, we_b, done_a, done_b;
    int done_cyc_a, done_cyc_b, nz_a, busy_low_a;
    logic [31:0] first_in_a, last_in_a, cap4_a;

    function automatic logic [2:0] widx(input int w);
        if (w == 0 || w == 8) return 3'd7;
        if (w == 7) return 3'd6;
        return 3'(w - 1);
    endfunction

    task automatic model_step(input int u);
        int gap;
        bit load;
        gap  = (u == 0) ? 2 : 0;
        load = 1'b0;
        if (reset) begin
            m_phase[u] = 0; m_word[u] = 0; m_cd[u] = 0; m_pend[u] = 1'b0;
            m_retry[u] = '0; m_idx[u] = '0; m_in[u] = '0;
            for (int i = 0; i < 8; i++) m_sh[u][i] = '0;
            return;
        end
        case (m_phase[u])
            0: if (mcu_commit) begin
                m_phase[u] = 1; m_word[u] = 0; m_cd[u] = 0; load = 1'b1;
            end
            1: begin
                if (mcu_commit) m_pend[u] = 1'b1;
                if (m_cd[u] == 0) begin
                    if (snescmd_wr_busy) begin
                        if (m_retry[u] != 8'hff) m_retry[u] = m_retry[u] + 8'd1;
                    end else if (m_word[u] == 8) begin
                        m_phase[u] = 2;
                    end else begin
                        m_word[u] = m_word[u] + 1;
                        m_cd[u] = gap;
                        if (gap == 0) load = 1'b1;
                    end
                end else begin
                    m_cd[u] = m_cd[u] - 1;
                    if (m_cd[u] == 0) load = 1'b1;
                end
            end
            default: begin
                if (m_pend[u] || mcu_commit) begin
                    m_phase[u] = 1; m_word[u] = 0; m_cd[u] = 0; m_pend[u] = 1'b0; load = 1'b1;
                end else begin
                    m_phase[u] = 0;
                end
            end
        endcase
        if (load) begin
            m_idx[u] = widx(m_word[u]);
            m_in[u]  = (m_word[u] == 0) ? 32'h0000_0010 : m_sh[u][m_idx[u]];
        end
        if (mcu_wr_strobe) m_sh[u][mcu_addr] = mcu_data;
    endtask

    function automatic logic [45:0] exp_vec(input int u);
        return {(m_phase[u] == 1 && m_cd[u] == 0), m_idx[u], m_in[u],
                (m_phase[u] != 0), (m_phase[u] == 2), m_retry[u]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        first_we_a = -1; first_we_b = -1; we_a = 0; we_b = 0; done_a = 0; done_b = 0;
        done_cyc_a = -1; done_cyc_b = -1; nz_a = 0; busy_low_a = 0;
        first_in_a = '0; last_in_a = '0; cap4_a = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cyc++;
        chk($sformatf("gap2_cyc%0d", cyc), {18'd0, a_we, a_idx, a_in, a_busy, a_done, a_retry},
            {18'd0, exp_vec(0)});
        chk($sformatf("gap0_cyc%0d", cyc), {18'd0, b_we, b_idx, b_in, b_busy, b_done, b_retry},
            {18'd0, exp_vec(1)});
        if (a_we) begin
            we_a++;
            if (first_we_a < 0) begin first_we_a = cyc; first_in_a = a_in; end
            last_in_a = a_in;
            if (a_in != 32'd0) nz_a++;
            if (a_idx == 3'd4) cap4_a = a_in;
        end
        if (b_we) begin
            we_b++;
            if (first_we_b < 0) first_we_b = cyc;
        end
        if (!a_busy && done_a < 2) busy_low_a++;
        if (a_done) begin done_a++; done_cyc_a = cyc; end
        if (b_done) begin done_b++; done_cyc_b = cyc; end
    endtask

    task automatic shadow_wr(input logic [2:0] addr, input logic [31:0] data);
        mcu_wr_strobe = 1'b1; mcu_addr = addr; mcu_data = data;
        tick();
        mcu_wr_strobe = 1'b0;
    endtask

    initial begin
        int t;
        reset = 1'b1; mcu_wr_strobe = 1'b0; mcu_addr = '0; mcu_data = '0;
        mcu_commit = 1'b0; snescmd_wr_busy = 1'b0;
        clear_mon();
        repeat (3) tick();
        chk("reset_state", {18'd0, a_we, a_idx, a_in, a_busy, a_done, a_retry}, 64'd0);
        reset = 1'b0;
        tick();

        // Basic replay, both gap settings
        shadow_wr(3'd0, 32'h00FF_EA42);
        shadow_wr(3'd6, 32'h0000_0001);
        shadow_wr(3'd7, 32'h0000_0001);
        tick();
        clear_mon(); t = cyc;
        mcu_commit = 1'b1; tick(); mcu_commit = 1'b0;
        repeat (30) tick();
        chk("t1_first_we", 64'(first_we_a - t), 64'd1);
        chk("t1_we_count", 64'(we_a), 64'd9);
        chk("t1_first_in", 64'(first_in_a), 64'h10);
        chk("t1_last_in", 64'(last_in_a), 64'h01);
        chk("t1_done_lat", 64'(done_cyc_a - t), 64'd26);
        chk("t6_first_we", 64'(first_we_b - t), 64'd1);
        chk("t6_we_count", 64'(we_b), 64'd9);
        chk("t6_done_lat", 64'(done_cyc_b - t), 64'd10);

        // Collision covering the ENTRY k=2 issue
        clear_mon(); t = cyc;
        mcu_commit = 1'b1; tick(); mcu_commit = 1'b0;
        repeat (34) begin
            snescmd_wr_busy = (cyc - t >= 10) && (cyc - t <= 12);
            tick();
        end
        snescmd_wr_busy = 1'b0;
        chk("t2_retry", 64'(a_retry), 64'd3);
        chk("t2_we_cycles", 64'(we_a), 64'd12);
        chk("t2_done_lat", 64'(done_cyc_a - t), 64'd29);

        // Commit coalescing
        clear_mon(); t = cyc;
        repeat (60) begin
            mcu_commit = (cyc - t == 0) || (cyc - t == 5) || (cyc - t == 12);
            tick();
        end
        mcu_commit = 1'b0;
        chk("t3_we_count", 64'(we_a), 64'd18);
        chk("t3_done_count", 64'(done_a), 64'd2);
        chk("t3_busy_gap", 64'(busy_low_a), 64'd0);

        // Reset during MASK
        clear_mon(); t = cyc;
        mcu_commit = 1'b1; tick(); mcu_commit = 1'b0;
        while (cyc - t < 22) tick();
        chk("t4_in_mask", {60'd0, a_we, a_idx}, {60'd0, 1'b1, 3'd6});
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t4_we_after_rst", 64'(a_we), 64'd0);
        chk("t4_busy_after_rst", 64'(a_busy), 64'd0);
        clear_mon();
        mcu_commit = 1'b1; tick(); mcu_commit = 1'b0;
        repeat (30) tick();
        chk("t4_zero_first_in", 64'(first_in_a), 64'h10);
        chk("t4_nonzero_words", 64'(nz_a), 64'd1);

        // Shadow write to entry 4 while ENTRY k=1 is issuing
        shadow_wr(3'd4, 32'h1111_1111);
        clear_mon(); t = cyc;
        mcu_commit = 1'b1; tick(); mcu_commit = 1'b0;
        repeat (30) begin
            mcu_wr_strobe = (cyc - t == 7); mcu_addr = 3'd4; mcu_data = 32'hA5A5_0404;
            tick();
        end
        mcu_wr_strobe = 1'b0;
        chk("t5_late_entry4", 64'(cap4_a), 64'hA5A5_0404);

        // Retry counter saturation
        mcu_commit = 1'b1; tick(); mcu_commit = 1'b0;
        snescmd_wr_busy = 1'b1;
        repeat (260) tick();
        chk("retry_saturate", 64'(a_retry), 64'hff);
        snescmd_wr_busy = 1'b0;
        repeat (30) tick();

        // Randomized traffic against the model
        repeat (500) begin
            mcu_commit      = ($urandom_range(0, 24) == 0);
            snescmd_wr_busy = ($urandom_range(0, 5) == 0);
            mcu_wr_strobe   = (m_phase[0] == 0) && (m_phase[1] == 0) && !mcu_commit &&
                              ($urandom_range(0, 1) == 1);
            mcu_addr        = 3'($urandom_range(0, 7));
            mcu_data        = $urandom;
            if (mcu_addr == 3'd6) mcu_data = mcu_data & 32'h3f;
            if (mcu_addr == 3'd7) mcu_data = mcu_data & 32'hff;
            tick();
        end
        mcu_commit = 1'b0; snescmd_wr_busy = 1'b0; mcu_wr_strobe = 1'b0;
        repeat (60) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
